psum_collector: RTL and testbench
=================================

Name: psum_collector

Overview:
- Receives the skewed partial-sum stream leaving the south edge of the systolic MAC array. Per column, it takes the psum bus and the per-column valid bits that the MAC row produces.
- Each column has its own FIFO that captures its words. This removes the one-cycle-per-column skew.
- Full output rows (all columns) are presented to the SFU/output-SRAM path under a simple read handshake.

Parameters:
- psum_bw, 16, width of one partial sum (two's complement)
- col, 8, number of array columns; one FIFO per column
- depth, 64, entries per column FIFO; power of two, >= 2

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in  input  psum_bw*col  psums from array; column i at bits [psum_bw*(i+1)-1 : psum_bw*i]
- valid  input  col  valid[i] qualifies column i of in for this cycle
- rd  input  1  pop one full row when o_valid=1
- out  output  psum_bw*col  registered row read out; same column packing as in
- o_valid  output  1  every column FIFO holds at least one entry
- o_full  output  1  at least one column FIFO holds depth entries
- o_ready  output  1  equals ~o_full
- overflow  output  1  sticky; a write was dropped

Behaviour:
- Reset (synchronous, active-high) applies on the edge where reset=1:
  - all read/write pointers and counts go to 0
  - out=0, overflow=0
  - o_valid=0, o_full=0, o_ready=1 are then derived from the cleared counts
  - Reset mid-operation discards all stored data; in/valid/rd are ignored during reset cycles.
- Column FIFO i, per edge:
  - push_i = valid[i] & (count_i < depth | pop).
  - pop = rd & o_valid; it is common to all columns.
  - Pointers wrap modulo depth. count_i is log2(depth)+1 bits.
- Simultaneous push and pop on a column:
  - Both take effect and count_i is unchanged.
  - This holds even when count_i == depth, so the write is accepted.
- Write to a full column without a pop:
  - The data is dropped and FIFO contents are unchanged.
  - overflow is set the next cycle and stays set until reset.
- Flag decode, combinational from the registered counts:
  - o_valid = AND over i of (count_i != 0)
  - o_full = OR over i of (count_i == depth)
- No write-to-read bypass:
  - A word pushed at edge t is first readable in the cycle after t.
  - o_valid cannot be raised by a same-cycle push.
- Read:
  - On the edge where pop=1, out is loaded with the head entry of every column and all read pointers advance by 1.
  - The row is visible in the cycle after rd (1-cycle latency).
- Read with o_valid=0: ignored; pointers and out hold.
- out holds its last value whenever no pop occurs.
- Skew: the array emits column i one cycle after column i-1. Column FIFOs are independent, so rows realign automatically; no timing relationship between valid bits is required.
- Data is stored unmodified. No arithmetic is performed except in the optional feature.

Optional Feature:
- Macro: PSUM_COLLECTOR_RELU_EN.
- When defined:
  - On the read path each column word with MSB=1 (negative) is loaded into out as 0; non-negative words pass unchanged.
  - FIFO contents are always raw.
- When undefined: out carries raw stored psums. No extra logic.

Test Plan:
1. Assert reset for 2 cycles -> out=0, o_valid=0, o_full=0, o_ready=1, overflow=0.
2. Skewed row:
   - Stimulus: valid[i] pulsed at cycle t+i with column i = 16'h0001+i, for i=0..7.
   - o_valid=0 through cycle t+7 and rises in cycle t+8.
   - rd at t+8 -> in cycle t+9, out = {16'h0008,...,16'h0001} and o_valid=0.
3. Fill:
   - Push 64 rows into all columns -> o_full=1, o_ready=0.
   - Push 65th row with rd=0 -> overflow=1.
   - Then 64 reads return rows 1..64 in order; 65th-row data never appears.
4. Full plus simultaneous pop:
   - With all counts 64, assert valid=8'hFF and rd together -> row accepted, counts stay 64, overflow stays 0, next 64 reads end with the new row.
5. Idle read and reset:
   - rd with o_valid=0 -> out unchanged.
   - Store 3 rows, assert reset 1 cycle -> out=0, o_valid=0, subsequent rd returns nothing new.
6. With PSUM_COLLECTOR_RELU_EN defined:
   - Row with column 0=16'hFFF0 and column 1=16'h0010 -> out column 0=0, column 1=16'h0010.
   - Without the macro, column 0=16'hFFF0.

Source files
------------

// File: rtl/psum_collector_if.sv
// Bus between the systolic array south edge (master) and the
// partial-sum collector (slave): skewed psum input, row read handshake
// and the status flags.
interface psum_collector_if #(
  parameter int psum_bw = 16,
  parameter int col     = 8
);
  logic [psum_bw*col-1:0] in;
  logic [col-1:0]         valid;
  logic                   rd;
  logic [psum_bw*col-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
  logic                   overflow;

  modport master (
    output in, valid, rd,
    input  out, o_valid, o_full, o_ready, overflow
  );

  modport slave (
    input  in, valid, rd,
    output out, o_valid, o_full, o_ready, overflow
  );
endinterface

// File: rtl/psum_collector.sv
// psum_collector: one FIFO per array column absorbs the per-column skew of
// the partial-sum stream; complete rows are popped with a 1-cycle read.
// Optional feature macro: PSUM_COLLECTOR_RELU_EN (clamp negative words to 0
// on the read path; FIFO contents stay raw).
module psum_collector #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 64
) (
  input logic              clk,
  input logic              reset,
  psum_collector_if.slave  bus
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_cnt = (aw+1)'(depth);

  logic [psum_bw-1:0] mem_r    [col][depth];
  logic [aw-1:0]      wr_ptr_r [col];
  logic [aw-1:0]      rd_ptr_r [col];
  logic [aw:0]        count_r  [col];
  logic [psum_bw*col-1:0] out_r;
  logic               overflow_r;

  logic [col-1:0]     push_s;
  logic               pop_s;
  logic               valid_s;
  logic               full_s;
  logic               drop_s;

  // Word presented on the read path; negative words clamp when ReLU is built in.
  function automatic logic [psum_bw-1:0] read_word(input logic [psum_bw-1:0] w);
`ifdef PSUM_COLLECTOR_RELU_EN
    if (w[psum_bw-1]) begin
      return '0;
    end else begin
      return w;
    end
`else
    return w;
`endif
  endfunction

  // Flag decode from registered counts, plus per-column push and the shared pop.
  always_comb begin
    valid_s = 1'b1;
    full_s  = 1'b0;
    for (int i = 0; i < col; i++) begin
      if (count_r[i] == '0) begin
        valid_s = 1'b0;
      end else begin
        valid_s = valid_s;
      end
      if (count_r[i] == full_cnt) begin
        full_s = 1'b1;
      end else begin
        full_s = full_s;
      end
    end
    pop_s  = bus.rd & valid_s;
    drop_s = 1'b0;
    for (int i = 0; i < col; i++) begin
      // A full column still accepts a write when the same edge pops it.
      push_s[i] = bus.valid[i] & ((count_r[i] < full_cnt) | pop_s);
      if (bus.valid[i] & ~push_s[i]) begin
        drop_s = 1'b1;
      end else begin
        drop_s = drop_s;
      end
    end
  end

  // FIFO storage; no reset needed since pointers/counts gate visibility.
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (!reset && push_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= bus.in[psum_bw*i +: psum_bw];
      end
    end
  end

  // Pointers, counts, read row register and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < col; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        count_r[i]  <= '0;
      end
      out_r      <= '0;
      overflow_r <= 1'b0;
    end else begin
      for (int i = 0; i < col; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + {{(aw-1){1'b0}}, 1'b1};
        end
        if (pop_s) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + {{(aw-1){1'b0}}, 1'b1};
          out_r[psum_bw*i +: psum_bw] <= read_word(mem_r[i][rd_ptr_r[i]]);
        end
        case ({push_s[i], pop_s})
          2'b10:   count_r[i] <= count_r[i] + {{aw{1'b0}}, 1'b1};
          2'b01:   count_r[i] <= count_r[i] - {{aw{1'b0}}, 1'b1};
          default: count_r[i] <= count_r[i];
        endcase
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign bus.out      = out_r;
  assign bus.o_valid  = valid_s;
  assign bus.o_full   = full_s;
  assign bus.o_ready  = ~full_s;
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: reset, skewed row, fill/overflow,
// full-with-pop, idle read, mid-run reset and the optional ReLU read path.
module tb_psum_collector;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  psum_collector_if #(.psum_bw(16), .col(8)) bus ();

  psum_collector #(.psum_bw(16), .col(8), .depth(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Row k: column i holds {k[7:0], i[7:0]}.
  function automatic logic [127:0] row_val(input int k);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[16*i +: 16] = 16'((k % 256) * 256 + i);
    end
    return r;
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int c = 0; c < n; c++) step();
    reset = 1'b0;
  endtask

  task automatic push_row(input logic [127:0] r);
    bus.in = r;
    bus.valid = 8'hFF;
    step();
    bus.valid = 8'h00;
  endtask

  task automatic read_row();
    bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
  endtask

  initial begin
    logic [127:0] row;
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b0;
    bus.in = '0;
    bus.valid = 8'h00;
    bus.rd = 1'b0;
    #2;

    // 1. Reset state
    do_reset(2);
    check("rst_out", bus.out, 128'h0);
    check("rst_o_valid", {127'h0, bus.o_valid}, 128'h0);
    check("rst_o_full", {127'h0, bus.o_full}, 128'h0);
    check("rst_o_ready", {127'h0, bus.o_ready}, 128'h1);
    check("rst_overflow", {127'h0, bus.overflow}, 128'h0);

    // 2. Skewed row: column i arrives in cycle t+i
    for (int i = 0; i < 8; i++) begin
      check("skew_o_valid_low", {127'h0, bus.o_valid}, 128'h0);
      bus.in = '0;
      bus.in[16*i +: 16] = 16'(i + 1);
      bus.valid = 8'(1 << i);
      step();
    end
    bus.valid = 8'h00;
    check("skew_o_valid_high", {127'h0, bus.o_valid}, 128'h1);
    read_row();
    check("skew_out", bus.out, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    check("skew_o_valid_after", {127'h0, bus.o_valid}, 128'h0);

    // 3. Fill to 64, overflow on the 65th row, then drain in order
    for (int k = 1; k <= 64; k++) push_row(row_val(k));
    check("fill_o_full", {127'h0, bus.o_full}, 128'h1);
    check("fill_o_ready", {127'h0, bus.o_ready}, 128'h0);
    check("fill_no_ovf", {127'h0, bus.overflow}, 128'h0);
    push_row(row_val(65));
    check("fill_overflow", {127'h0, bus.overflow}, 128'h1);
    for (int k = 1; k <= 64; k++) begin
      read_row();
      check($sformatf("drain_row%0d", k), bus.out, row_val(k));
    end
    check("drain_o_valid", {127'h0, bus.o_valid}, 128'h0);
    read_row();
    check("drain_no_65th", bus.out, row_val(64));
    check("ovf_sticky", {127'h0, bus.overflow}, 128'h1);

    // 4. Full plus simultaneous pop
    do_reset(1);
    check("ovf_cleared", {127'h0, bus.overflow}, 128'h0);
    for (int k = 1; k <= 64; k++) push_row(row_val(k));
    bus.in = row_val(100);
    bus.valid = 8'hFF;
    bus.rd = 1'b1;
    step();
    bus.valid = 8'h00;
    bus.rd = 1'b0;
    check("fullpop_out", bus.out, row_val(1));
    check("fullpop_no_ovf", {127'h0, bus.overflow}, 128'h0);
    check("fullpop_still_full", {127'h0, bus.o_full}, 128'h1);
    for (int k = 2; k <= 64; k++) begin
      read_row();
      check($sformatf("fullpop_row%0d", k), bus.out, row_val(k));
    end
    read_row();
    check("fullpop_new_row", bus.out, row_val(100));
    check("fullpop_empty", {127'h0, bus.o_valid}, 128'h0);

    // 5. Idle read holds out; reset discards stored rows
    read_row();
    check("idle_read_hold", bus.out, row_val(100));
    for (int k = 1; k <= 3; k++) push_row(row_val(200 + k));
    check("three_rows_valid", {127'h0, bus.o_valid}, 128'h1);
    do_reset(1);
    check("midrst_out", bus.out, 128'h0);
    check("midrst_o_valid", {127'h0, bus.o_valid}, 128'h0);
    read_row();
    check("midrst_read_nothing", bus.out, 128'h0);

    // 6. Sign handling on the read path
    row = '0;
    row[15:0] = 16'hFFF0;
    row[31:16] = 16'h0010;
    push_row(row);
    read_row();
`ifdef PSUM_COLLECTOR_RELU_EN
    check("relu_row", bus.out, 128'h0000_0000_0000_0000_0000_0000_0010_0000);
`else
    check("raw_row", bus.out, 128'h0000_0000_0000_0000_0000_0000_0010_FFF0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
